store_rmw_unit: RTL and testbench

Store-side counterpart of the load/immediate extension path: takes a 32-bit register value and writes its low byte, low halfword or full word into word-addressed memory. Sub-word stores run a read-modify-write: fetch the containing word, merge the truncated data into the addressed lane, write the word back. The block sits between the control FSM (start/done handshake) and the memory port, after the ALU-computed address.

---
 rtl/store_rmw_unit.sv | 194 +++++++++++++++++++
 tb/tb_store_rmw_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/store_rmw_unit.sv
// store_rmw_unit
//   Stores the low byte, low halfword or full word of a register value into
//   word-addressed memory. Word stores write directly. Sub-word stores read
//   the containing word, merge the new data into the addressed lane(s) and
//   write the merged word back.
//
// Optional feature macro: STORE_ALIGN_CHECK_EN
//   When defined, misaligned half/word requests finish with done=1, err=1 and
//   touch no memory. When undefined, err is tied to 0, word stores ignore
//   addr[1:0] and half stores ignore addr[0].
//
// Parameters
//   MEM_RD_LAT  cycles from a stable mem_addr until mem_rdata is valid (1..7)
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   start       one-cycle request, sampled only in IDLE
//   size        00 word, 01 half, 10 byte, 11 word
//   addr        byte address
//   store_data  register value; low 8/16 bits used for byte/half
//   mem_rdata   memory read data
//   mem_addr    word-aligned memory address
//   mem_wdata   word to write
//   mem_wr      one-cycle write strobe
//   busy        high from the cycle after accept through the done cycle
//   done        one-cycle completion pulse
//   err         alignment error, valid with done

// One byte lane of the read-modify-write merge: picks either the new data
// byte or the byte read back from memory.
module store_rmw_lane #(
  parameter int LANE  = 0,
  parameter int VEC_W = 8
) (
  input  logic [1:0]         addr_lo,
  input  logic [1:0]         size,
  input  logic [2*VEC_W-1:0] src,
  input  logic [VEC_W-1:0]   rd,
  output logic [VEC_W-1:0]   wr
);
  localparam logic [1:0] LID = 2'(LANE);

  logic byte_hit, half_hit;

  assign byte_hit = (size == 2'b10) && (addr_lo == LID);
  assign half_hit = (size == 2'b01) && (addr_lo[1] == LID[1]);

  // Within a halfword, the upper byte lane takes src[15:8].
  always_comb begin
    wr = rd;
    if (byte_hit)      wr = src[VEC_W-1:0];
    else if (half_hit) wr = LID[0] ? src[2*VEC_W-1:VEC_W] : src[VEC_W-1:0];
  end
endmodule

module store_rmw_unit #(
  parameter int MEM_RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state_q, state_nxt;
  logic [2:0]  cnt_q, cnt_nxt;
  logic [1:0]  addr_q;
  logic [1:0]  size_q;
  logic [15:0] data_q;
  logic        accept, capture;
  logic        sub_word, misalign;

  logic [NUM_LANES-1:0][VEC_W-1:0] rd_lanes, wr_lanes;

  assign sub_word = (size == 2'b01) || (size == 2'b10);

`ifdef STORE_ALIGN_CHECK_EN
  always_comb begin
    misalign = 1'b0;
    case (size)
      2'b01:   misalign = addr[0];
      2'b10:   misalign = 1'b0;
      default: misalign = (addr[1:0] != 2'b00);
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  // Merge datapath: one lane instance per byte of the memory word.
  assign rd_lanes = mem_rdata;

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      store_rmw_lane #(.LANE(g), .VEC_W(VEC_W)) u_lane (
        .addr_lo (addr_q),
        .size    (size_q),
        .src     (data_q),
        .rd      (rd_lanes[g]),
        .wr      (wr_lanes[g])
      );
    end
  endgenerate

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (misalign) begin
            state_nxt = DONE;
          end else if (sub_word) begin
            state_nxt = READ;
            cnt_nxt   = 3'(MEM_RD_LAT - 1);
          end else begin
            state_nxt = WRITE;
          end
        end
      end
      READ: begin
        if (cnt_q == 3'd0) begin
          capture   = 1'b1;
          state_nxt = WRITE;
        end else begin
          cnt_nxt = cnt_q - 3'd1;
        end
      end
      WRITE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with
  // the state they describe without any input-to-output combinational path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      size_q    <= '0;
      data_q    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wr    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      if (accept) begin
        addr_q   <= addr[1:0];
        size_q   <= size;
        data_q   <= store_data[15:0];
        mem_addr <= {addr[31:2], 2'b00};
        if (!sub_word) mem_wdata <= store_data;
      end
      if (capture) mem_wdata <= wr_lanes;
      mem_wr <= (state_nxt == WRITE);
      busy   <= (state_nxt != IDLE);
      done   <= (state_nxt == DONE);
    end
  end

`ifdef STORE_ALIGN_CHECK_EN
  // err is held after done so it can be read late; the next accept clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      err <= 1'b0;
    else if (accept) err <= misalign;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_store_rmw_unit.sv
module tb_store_rmw_unit;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_wr, busy, done, err;

  int n_pass = 0;
  int n_tot  = 0;
  int wr_cnt = 0;
  logic [31:0] exp_q [$];

  store_rmw_unit #(.MEM_RD_LAT(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .size       (size),
    .addr       (addr),
    .store_data (store_data),
    .mem_rdata  (mem_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wr     (mem_wr),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Counts write pulses at the edge that ends each mem_wr cycle.
  always @(posedge clk) if (mem_wr) wr_cnt <= wr_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Pops the scoreboard and compares against the word on the write port.
  task automatic pop_chk(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_tot++;
      $error("FAIL %s: got write %h expected no write", tag, mem_wdata);
    end else begin
      e = exp_q.pop_front();
      chk(tag, mem_wdata, e);
    end
  endtask

  // Returns on the negedge of cycle E+1 with inputs scrambled.
  task automatic do_start(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    size = sz; addr = a; store_data = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    size = 2'($urandom); addr = $urandom; store_data = $urandom;
  endtask

  // cyc counts from 1 at the current negedge; -1 if no write within budget.
  task automatic wait_wr(input int budget, output int cyc);
    cyc = 1;
    while (!mem_wr && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (!mem_wr) cyc = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int c, w0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ctl", {28'd0, mem_wr, busy, done, err}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    reset = 1'b1;

    // word store: write at E+1, done at E+2, no read
    exp_q.push_back(32'hDEADBEEF);
    do_start(2'b00, 32'h0000_0104, 32'hDEAD_BEEF);
    chk("w_wr", mem_wr, 1);
    chk("w_addr", mem_addr, 32'h104);
    chk("w_busy", busy, 1);
    pop_chk("w_data");
    @(negedge clk);
    chk("w_done", {done, mem_wr, err}, 3'b100);
    @(negedge clk);
    chk("w_idle", {busy, done}, 2'b00);

    // byte store at lane 2, LAT=2: write at E+3
    mem_rdata = 32'h1122_3344;
    exp_q.push_back(32'h11A5_3344);
    do_start(2'b10, 32'h0000_0206, 32'h1234_56A5);
    wait_wr(8, c);
    chk("b_lat", c, 3);
    chk("b_addr", mem_addr, 32'h204);
    pop_chk("b_data");
    @(negedge clk);
    chk("b_done", {done, busy, mem_wr}, 3'b110);

    // half store at upper half
    mem_rdata = 32'hAABB_CCDD;
    exp_q.push_back(32'h8001_CCDD);
    do_start(2'b01, 32'h0000_0012, 32'hFFFF_8001);
    wait_wr(8, c);
    chk("h_lat", c, 3);
    chk("h_addr", mem_addr, 32'h10);
    pop_chk("h_data");
    @(negedge clk);
    chk("h_done", done, 1);

    // start pulsed during READ is ignored; start right after done accepted
    w0 = wr_cnt;
    mem_rdata = 32'hCAFE_F00D;
    exp_q.push_back(32'hCAFE_770D);
    do_start(2'b10, 32'h0000_0101, 32'h0000_0077);
    start = 1'b1; size = 2'b00; addr = 32'h500; store_data = 32'h9999_9999;
    @(negedge clk);
    start = 1'b0;
    wait_wr(6, c);
    chk("ign_lat", c, 2);
    chk("ign_addr", mem_addr, 32'h100);
    pop_chk("ign_data");
    @(negedge clk);
    chk("ign_done", done, 1);
    exp_q.push_back(32'h0102_0304);
    do_start(2'b00, 32'h0000_0040, 32'h0102_0304);
    chk("b2b_wr", mem_wr, 1);
    chk("b2b_addr", mem_addr, 32'h40);
    pop_chk("b2b_data");
    repeat (3) @(negedge clk);
    chk("ign_wrcnt", wr_cnt - w0, 2);

    // reset during READ
    mem_rdata = 32'h5566_7788;
    do_start(2'b10, 32'h0000_0208, 32'h0000_00AB);
    chk("r_busy", busy, 1);
    w0 = wr_cnt;
    reset = 1'b0;
    #1;
    chk("r_ctl", {28'd0, mem_wr, busy, done, err}, 32'd0);
    chk("r_addr", mem_addr, 32'd0);
    chk("r_wdata", mem_wdata, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("r_nowr", wr_cnt - w0, 0);
    chk("r_idle", busy, 0);
    mem_rdata = 32'h1122_3344;
    exp_q.push_back(32'hA522_3344);
    do_start(2'b10, 32'h0000_0003, 32'h0000_00A5);
    wait_wr(8, c);
    chk("r_b3_lat", c, 3);
    chk("r_b3_addr", mem_addr, 32'h0);
    pop_chk("r_b3_data");
    @(negedge clk);
    chk("r_b3_done", done, 1);

    // half store at addr 1
    mem_rdata = 32'h1122_3344;
`ifdef STORE_ALIGN_CHECK_EN
    w0 = wr_cnt;
    do_start(2'b01, 32'h0000_0001, 32'h0000_BEEF);
    chk("mis_done", {done, err, mem_wr}, 3'b110);
    @(negedge clk);
    chk("mis_idle", {busy, err}, 2'b01);
    chk("mis_nowr", wr_cnt - w0, 0);
    exp_q.push_back(32'h0000_0001);
    do_start(2'b00, 32'h0000_0008, 32'h0000_0001);
    chk("mis_clr", err, 0);
    pop_chk("mis_next");
    @(negedge clk);
`else
    exp_q.push_back(32'h1122_BEEF);
    do_start(2'b01, 32'h0000_0001, 32'h0000_BEEF);
    wait_wr(8, c);
    chk("h1_lat", c, 3);
    chk("h1_addr", mem_addr, 32'h0);
    pop_chk("h1_data");
    @(negedge clk);
    chk("h1_done", {done, err}, 2'b10);
`endif

    chk("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
